// File: rtl/cpu_fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end: fetch FSM states, queue entry
// layout and the sequential-PC helper.
package cpu_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + INSN_BYTES;
  endfunction

endpackage

// File: rtl/cpu_fetch_unit_ibuf.sv
// In-order instruction queue. The head is read directly from the storage registers,
// so the consumer never sees a same-cycle bypass from the push side.
module cpu_ibuf #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is cleared on reset so the head reads as all-zero until the first push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch front end: PC generation, req/gnt/rvalid memory port, credit
// control of outstanding requests, redirect flush/squash and the Q2 valid/ready output.
module cpu_fetch_unit
  import cpu_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          IBUF_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_br_redirect,
  input  logic [31:0] i_br_target,
  input  logic        i_jal_redirect,
  input  logic [31:0] i_jal_target,
  output logic        o_insn_valid,
  input  logic        i_insn_ready,
  output logic [31:0] o_insn,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_incr,
  output logic        o_misaligned
);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // Stale responses can pile up over back-to-back redirects, so the drop counter has headroom.
  localparam int DW = $clog2(8 * MAX_OUTSTANDING + 1);

  fetch_state_t  r_state;
  logic          r_started;
  logic          r_misaligned;
  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [OW-1:0] r_outstanding;
  logic [DW-1:0] r_drop_cnt;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_target_misaligned;
  logic [CW:0]   w_credit_sum;
  logic          w_fire;
  logic          w_dropping;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_owed;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_wentry;
  fetch_entry_t  w_head;

  assign w_redirect          = i_br_redirect | i_jal_redirect;
  assign w_target            = i_br_redirect ? i_br_target : i_jal_target;
  assign w_target_misaligned = (w_target[1:0] != 2'b00);

  // Credits use registered counts only; a pop this cycle frees its slot next cycle.
  assign w_credit_sum = (CW+1)'(w_count) + (CW+1)'(r_outstanding);
  assign o_imem_req   = r_started & (r_state == ST_RUN) & ~w_redirect
                      & (w_credit_sum < (CW+1)'(IBUF_DEPTH))
                      & (r_outstanding < OW'(MAX_OUTSTANDING));
  assign o_imem_addr  = r_pc & ~32'h3;

  assign w_fire     = o_imem_req & i_imem_gnt;
  assign w_dropping = (r_drop_cnt != '0);
  assign w_push     = i_imem_rvalid & ~w_dropping & ~w_redirect;
  assign w_owed     = r_drop_cnt + DW'(r_outstanding);

  assign o_insn_valid = ~w_empty & ~w_redirect;
  assign w_pop        = o_insn_valid & i_insn_ready;

  assign w_wentry.insn = i_imem_rdata;
  assign w_wentry.pc   = r_rsp_pc;
  assign o_insn        = w_head.insn;
  assign o_pc          = w_head.pc;
  assign o_pc_incr     = next_pc(w_head.pc);
  assign o_misaligned  = r_misaligned;

  cpu_ibuf #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_wentry),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_RUN;
      r_started     <= 1'b0;
      r_misaligned  <= 1'b0;
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_started    <= 1'b1;
      r_misaligned <= 1'b0;
      if (w_redirect) begin
        r_pc          <= w_target;
        r_rsp_pc      <= w_target;
        r_outstanding <= '0;
        // Everything still owed belongs to the old stream, minus a response landing now.
        r_drop_cnt    <= w_owed - DW'(i_imem_rvalid && (w_owed != '0));
        if (w_target_misaligned) begin
          r_state      <= ST_HALT;
          r_misaligned <= 1'b1;
        end else begin
          r_state <= ST_RUN;
        end
      end else begin
        if (w_fire) r_pc <= next_pc(r_pc);
        if (i_imem_rvalid) begin
          if (w_dropping) r_drop_cnt <= r_drop_cnt - DW'(1);
          else            r_rsp_pc   <= next_pc(r_rsp_pc);
        end
        r_outstanding <= r_outstanding + OW'(w_fire) - OW'(w_push);
      end
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_imem_rvalid && !w_redirect && !w_dropping && w_full));

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Scoreboard bench for cpu_fetch_unit: in-order memory model with variable latency,
// expected instruction stream derived from redirect targets, directed timing checks.
module tb_cpu_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req, gnt, rvalid, br, jal, valid, ready, mis;
  logic [31:0] addr, rdata, br_t, jal_t, insn, pc, pc_incr;
  logic        gnt_en = 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_fetch_unit #(
    .RESET_PC        (RST_PC),
    .IBUF_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .o_imem_req     (req),
    .o_imem_addr    (addr),
    .i_imem_gnt     (gnt),
    .i_imem_rvalid  (rvalid),
    .i_imem_rdata   (rdata),
    .i_br_redirect  (br),
    .i_br_target    (br_t),
    .i_jal_redirect (jal),
    .i_jal_target   (jal_t),
    .o_insn_valid   (valid),
    .i_insn_ready   (ready),
    .o_insn         (insn),
    .o_pc           (pc),
    .o_pc_incr      (pc_incr),
    .o_misaligned   (mis)
  );

  assign gnt = req & gnt_en;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Memory model: in-order responses, each no earlier than grant + lat.
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t pend[$];
  int lat = 1;
  int gnt_pct = 100;

  initial forever begin
    @(posedge clk); #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rvalid = 1'b1;
      rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    gnt_en = ($urandom_range(99) < gnt_pct);
  end

  // Fetch-side model: expected request addresses follow the current target stream.
  logic [31:0] exp_fetch;
  bit          halted;
  int          n_grants = 0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (br || jal) chk("req_low_in_redirect", {31'd0, req}, 32'd0);
      else if (halted) chk("req_low_in_halt", {31'd0, req}, 32'd0);
      if (req && gnt) begin
        chk("fetch_addr", addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
        n_grants++;
        pend.push_back('{addr, cyc + lat});
      end
    end
  end

  // Output scoreboard: expected PCs are queued when a stream starts, popped per handshake.
  logic [31:0] exp_q[$];
  int n_pops = 0;
  int n_mis = 0;
  int exp_mis = 0;

  initial forever begin
    logic [31:0] p;
    @(negedge clk);
    if (mis === 1'b1) n_mis++;
    if (br || jal) begin
      chk("valid_low_in_redirect", {31'd0, valid}, 32'd0);
    end else if (valid && ready) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got pc %h expected no instruction (cycle %0d)", pc, cyc);
      end else begin
        p = exp_q.pop_front();
        chk("head_pc", pc, p);
        chk("head_insn", insn, mem_word(p));
        chk("head_pc_incr", pc_incr, p + 32'd4);
      end
    end
  end

  task automatic load_stream(input logic [31:0] t);
    exp_q.delete();
    exp_fetch = t;
    for (int k = 0; k < 512; k++) exp_q.push_back(t + 32'(4 * k));
  endtask

  // Drives a one-cycle redirect; call just after a rising edge.
  task automatic do_redirect(input bit b, input bit j, input logic [31:0] bt, input logic [31:0] jt);
    logic [31:0] t;
    t = b ? bt : jt;
    br = b; jal = j; br_t = bt; jal_t = jt;
    halted = (t[1:0] != 2'b00);
    if (halted) begin
      exp_q.delete();
      exp_mis++;
    end else begin
      load_stream(t);
    end
    @(posedge clk); #1;
    br = 1'b0; jal = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    bit b, j;
    logic [31:0] bt, jt;
    br = 0; jal = 0; br_t = 0; jal_t = 0; ready = 1; rvalid = 0; rdata = 0;
    halted = 0;
    load_stream(RST_PC);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_addr", addr, RST_PC);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_insn", insn, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_pc_incr", pc_incr, 32'd4);
    chk("rst_mis", {31'd0, mis}, 32'd0);

    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("req_before_first_edge", {31'd0, req}, 32'd0);
    @(negedge clk); chk("req_after_first_edge", {31'd0, req}, 32'd1);
                    chk("first_addr", addr, RST_PC);
    @(negedge clk); chk("valid_grant_plus1", {31'd0, valid}, 32'd0);
    @(negedge clk); chk("valid_grant_plus2", {31'd0, valid}, 32'd1);
                    chk("first_pc", pc, RST_PC);

    // Sustained stream across the 2^32 wrap.
    repeat (5) @(negedge clk);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid && ready) n++;
    end
    chk("throughput_10_cycles", n, 10);

    // Back-pressure.
    @(posedge clk); #1 ready = 1'b0;
    n = n_grants;
    repeat (6) @(negedge clk);
    chk("bp_req_stopped", {31'd0, req}, 32'd0);
    chk("bp_valid_held", {31'd0, valid}, 32'd1);
    chk("bp_grants_bounded", {31'd0, (n_grants - n) <= DEPTH}, 32'd1);
    @(posedge clk); #1 ready = 1'b1;
    repeat (10) @(posedge clk);

    // Branch squash with two requests outstanding at 3-cycle latency.
    lat = 3;
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(posedge clk); #2;
      if (pend.size() == 2 && !rvalid) found = 1;
    end
    chk("squash_setup_found", {31'd0, found}, 32'd1);
    n = n_pops;
    do_redirect(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    @(negedge clk);
    chk("squash_req", {31'd0, req}, 32'd1);
    chk("squash_addr", addr, 32'h0000_0100);
    repeat (20) @(posedge clk);
    chk("squash_progress", {31'd0, (n_pops - n) >= 3}, 32'd1);

    // Simultaneous JAL and branch: branch wins.
    lat = 1;
    repeat (8) @(posedge clk);
    #1 do_redirect(1'b1, 1'b1, 32'h0000_0080, 32'h0000_0040);
    @(negedge clk);
    chk("simul_req", {31'd0, req}, 32'd1);
    chk("simul_addr", addr, 32'h0000_0080);
    @(negedge clk); chk("simul_valid_r2", {31'd0, valid}, 32'd0);
    @(negedge clk); chk("simul_valid_r3", {31'd0, valid}, 32'd1);
                    chk("simul_pc_r3", pc, 32'h0000_0080);

    // Misaligned target halts, aligned redirect resumes.
    @(posedge clk); #1 do_redirect(1'b0, 1'b1, 32'h0, 32'h0000_0102);
    @(negedge clk);
    chk("mis_pulse", {31'd0, mis}, 32'd1);
    chk("mis_no_req", {31'd0, req}, 32'd0);
    @(negedge clk); chk("mis_pulse_end", {31'd0, mis}, 32'd0);
    repeat (6) @(negedge clk);
    chk("halt_no_valid", {31'd0, valid}, 32'd0);
    @(posedge clk); #1 do_redirect(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    @(negedge clk);
    chk("resume_req", {31'd0, req}, 32'd1);
    chk("resume_addr", addr, 32'h0000_0200);
    repeat (10) @(posedge clk);

    // Randomized traffic.
    gnt_pct = 70;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      ready = ($urandom_range(99) < 75);
      if (c % 50 == 0) lat = $urandom_range(1, 3);
      if ($urandom_range(99) < 4) begin
        b  = 1'($urandom_range(1));
        j  = !b || ($urandom_range(1) == 1);
        bt = $urandom & ~32'h3;
        jt = $urandom & ~32'h3;
        if ($urandom_range(9) == 0) begin
          if (b) bt[1:0] = 2'($urandom_range(1, 3));
          else   jt[1:0] = 2'($urandom_range(1, 3));
        end
        do_redirect(b, j, bt, jt);
      end
    end

    lat = 1; gnt_pct = 100;
    @(posedge clk); #1 ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("mis_pulse_count", n_mis, exp_mis);
    chk("pops_progress", {31'd0, n_pops > 150}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
